sha256_round_ctrl: RTL and testbench

Round sequencer for the SHA-256 compression core. It accepts one 512-bit block per start handshake. It then steps the 64 rounds, driving the K-constant ROM's enable/address and the compression datapath's load/round/final strobes. During rounds 0-15 it pulls message words from the upstream word stream, and it signals completion with a one-cycle done pulse.

---
 rtl/sha256_defs.sv | 16 +
 rtl/sha256_round_ctrl.sv | 116 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_defs.sv
// Shared definitions for the SHA-256 compression core: controller state encoding and round counts.
package sha256_defs;

  localparam int unsigned SHA256_ROUNDS    = 64;
  localparam int unsigned SHA256_MSG_WORDS = 16;
  localparam int unsigned SHA256_RND_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the SHA-256 compression core: steps INIT, the compression rounds,
// FINAL and DONE, driving the K ROM and the datapath strobes.
module sha256_round_ctrl
  import sha256_defs::*;
#(
  parameter int unsigned ROUNDS    = SHA256_ROUNDS,
  parameter int unsigned MSG_WORDS = SHA256_MSG_WORDS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    first_i,
  input  logic                    abort_i,
  output logic                    ready_o,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic                    k_en_o,
  output logic [SHA256_RND_W-1:0] k_addr_o,
  output logic                    iv_load_o,
  output logic                    init_o,
  output logic                    round_en_o,
  output logic                    w_src_o,
  output logic                    final_o,
  output logic                    done_o
);

  localparam int unsigned RW = SHA256_RND_W;
  localparam logic [RW-1:0] LAST_RND  = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] MSG_LIMIT = RW'(MSG_WORDS);

  state_e        state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic          first_q, first_d;
  logic          msg_phase_c;

  assign msg_phase_c = (rnd_q < MSG_LIMIT);

  // State, round counter and latched first flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
    end
  end

  // Next state; abort overrides any advance, including the last-round one
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          first_d = first_i;
          rnd_d   = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT:  state_d = ST_ROUND;
      ST_ROUND: begin
        if (round_en_o) begin
          if (rnd_q == LAST_RND) begin
            rnd_d   = '0;
            state_d = ST_FINAL;
          end else begin
            rnd_d = rnd_q + RW'(1);
          end
        end
      end
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q == ST_INIT || state_q == ST_ROUND || state_q == ST_FINAL)) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
    end
  end

  // Strobes decoded from registered state; word handshake also follows w_valid_i
  always_comb begin
    ready_o    = 1'b0;
    w_ready_o  = 1'b0;
    k_en_o     = 1'b0;
    k_addr_o   = '0;
    iv_load_o  = 1'b0;
    init_o     = 1'b0;
    round_en_o = 1'b0;
    w_src_o    = 1'b0;
    final_o    = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_INIT: begin
        init_o    = 1'b1;
        iv_load_o = first_q;
      end
      ST_ROUND: begin
        k_en_o     = 1'b1;
        k_addr_o   = rnd_q;
        w_src_o    = ~msg_phase_c;
        round_en_o = msg_phase_c ? w_valid_i : 1'b1;
        w_ready_o  = msg_phase_c & w_valid_i;
      end
      ST_FINAL: final_o = 1'b1;
      ST_DONE:  done_o  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: directed scenarios plus randomized traffic
// against a position-based reference model.
module tb_sha256_round_ctrl;

  localparam int NR = 64;
  localparam int NM = 16;
  localparam int TMAX = 160;

  // Observation vector bit positions
  localparam int B_RDY = 14, B_WR = 13, B_KEN = 12, B_IV = 5, B_INIT = 4;
  localparam int B_REN = 3, B_WSRC = 2, B_FIN = 1, B_DONE = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, first_i = 1'b0, abort_i = 1'b0, w_valid_i = 1'b0;
  logic       ready_o, w_ready_o, k_en_o, iv_load_o, init_o, round_en_o, w_src_o, final_o, done_o;
  logic [5:0] k_addr_o;
  logic [14:0] obs;
  logic [14:0] trace [0:TMAX];

  int checks = 0;
  int failures = 0;
  int m_pos = -1;     // -1 idle, 0 init, 1..NR round (index pos-1), NR+1 final, NR+2 done
  bit m_first = 1'b0;

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_i(first_i), .abort_i(abort_i),
    .ready_o(ready_o), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .k_en_o(k_en_o),
    .k_addr_o(k_addr_o), .iv_load_o(iv_load_o), .init_o(init_o), .round_en_o(round_en_o),
    .w_src_o(w_src_o), .final_o(final_o), .done_o(done_o)
  );

  assign obs = {ready_o, w_ready_o, k_en_o, k_addr_o, iv_load_o, init_o, round_en_o,
                w_src_o, final_o, done_o};

  function automatic logic [14:0] model_out(int pos, bit first, bit wv);
    logic [14:0] v = '0;
    int r;
    if (pos < 0) v[B_RDY] = 1'b1;
    else if (pos == 0) begin
      v[B_INIT] = 1'b1;
      v[B_IV] = first;
    end else if (pos <= NR) begin
      r = pos - 1;
      v[B_KEN] = 1'b1;
      v[11:6] = 6'(r);
      v[B_WSRC] = (r >= NM);
      v[B_REN] = (r >= NM) ? 1'b1 : wv;
      v[B_WR] = (r < NM) && wv;
    end else if (pos == NR + 1) v[B_FIN] = 1'b1;
    else v[B_DONE] = 1'b1;
    return v;
  endfunction

  function automatic int model_next(int pos, bit s, bit a, bit wv);
    if (pos < 0) return s ? 0 : -1;
    if (a && pos <= NR + 1) return -1;
    if (pos == 0) return 1;
    if (pos <= NR) return ((pos - 1) >= NM || wv) ? pos + 1 : pos;
    if (pos == NR + 1) return NR + 2;
    return -1;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then apply new inputs
  task automatic step(input bit s, input bit f, input bit a, input bit wv);
    @(posedge clk);
    if (!rst_n) begin
      m_pos = -1;
      m_first = 1'b0;
    end else begin
      if (m_pos < 0 && start_i) m_first = first_i;
      m_pos = model_next(m_pos, start_i, abort_i, w_valid_i);
    end
    #1;
    start_i = s; first_i = f; abort_i = a; w_valid_i = wv;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start_i = 1'b0; first_i = 1'b0; abort_i = 1'b0; w_valid_i = 1'b0;
    m_pos = -1;
    m_first = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one block from an accepting start at t=0, recording outputs per cycle in trace[]
  task automatic run_block(input bit f, input int stall_t, input int stall_n, input int abort_t,
                           input bit hold_start, input int ncyc, output int merr);
    logic [14:0] e;
    merr = 0;
    for (int t = 0; t <= ncyc; t++) begin
      if (t == 0) step(1'b1, f, 1'b0, 1'b1);
      else step(hold_start, f, (t == abort_t),
                !(t >= stall_t && t < stall_t + stall_n));
      trace[t] = obs;
      e = model_out(m_pos, m_first, w_valid_i);
      if (obs !== e) begin
        if (merr == 0) $display("  model diff t=%0d obs=%h exp=%h", t, obs, e);
        merr++;
      end
    end
  endtask

  function automatic int first_t(int bitn, int from, int upto);
    for (int t = from; t <= upto; t++) if (trace[t][bitn]) return t;
    return -1;
  endfunction

  function automatic int count_t(int bitn, int upto);
    int n = 0;
    for (int t = 0; t <= upto; t++) if (trace[t][bitn]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b1; first_i = 1'b1; abort_i = 1'b1; w_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 15'h4000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 15'h4000);
    end
    start_i = 1'b0; first_i = 1'b0; abort_i = 1'b0; w_valid_i = 1'b0;
    m_pos = -1; m_first = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 15'h4000) begin
      failures++;
      $display("FAIL after_reset_idle got=%h want=%h", obs, 15'h4000);
    end
  endtask

  task automatic test_nominal();
    int merr, v;
    bit ok = 1'b1;
    apply_reset();
    run_block(1'b1, -1, 0, -1, 1'b0, 72, merr);
    checks++; if (merr !== 0) begin failures++; $display("FAIL nominal_model got=%0d diffs want=0", merr); end
    v = first_t(B_IV, 0, 72);
    checks++; if (v !== 1) begin failures++; $display("FAIL nominal_iv_cycle got=%0d want=1", v); end
    v = first_t(B_INIT, 0, 72);
    checks++; if (v !== 1) begin failures++; $display("FAIL nominal_init_cycle got=%0d want=1", v); end
    for (int t = 2; t <= 65; t++) if (trace[t][11:6] !== 6'(t - 2) || !trace[t][B_KEN]) ok = 1'b0;
    v = count_t(B_KEN, 72);
    checks++; if (!ok || v !== NR) begin failures++; $display("FAIL nominal_kaddr ok=%0d kcount=%0d want 1/64", ok, v); end
    v = count_t(B_WR, 72);
    checks++; if (v !== NM) begin failures++; $display("FAIL nominal_wready_count got=%0d want=%0d", v, NM); end
    v = first_t(B_FIN, 0, 72);
    checks++; if (v !== 66) begin failures++; $display("FAIL nominal_final got=%0d want=66", v); end
    v = first_t(B_DONE, 0, 72);
    checks++; if (v !== 67) begin failures++; $display("FAIL nominal_done got=%0d want=67", v); end
    v = first_t(B_RDY, 1, 72);
    checks++; if (v !== 68) begin failures++; $display("FAIL nominal_ready_back got=%0d want=68", v); end
  endtask

  task automatic test_stall();
    int merr, v;
    bit ok = 1'b1;
    apply_reset();
    run_block(1'b0, 7, 3, -1, 1'b0, 74, merr);
    checks++; if (merr !== 0) begin failures++; $display("FAIL stall_model got=%0d diffs want=0", merr); end
    for (int t = 7; t <= 9; t++) if (trace[t][11:6] !== 6'd5 || trace[t][B_REN] || trace[t][B_WR]) ok = 1'b0;
    if (trace[10][11:6] !== 6'd5 || !trace[10][B_REN] || trace[11][11:6] !== 6'd6) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL stall_hold got=0 want=1"); end
    v = first_t(B_DONE, 0, 74);
    checks++; if (v !== 70) begin failures++; $display("FAIL stall_done got=%0d want=70", v); end
  endtask

  task automatic test_abort_mid();
    int merr, v;
    apply_reset();
    run_block(1'b0, -1, 0, 42, 1'b0, 50, merr);
    checks++; if (merr !== 0) begin failures++; $display("FAIL abort_mid_model got=%0d diffs want=0", merr); end
    checks++;
    if (trace[42][11:6] !== 6'd40 || !trace[43][B_RDY]) begin
      failures++;
      $display("FAIL abort_mid_idle got addr=%0d rdy=%0d want 40/1", trace[42][11:6], trace[43][B_RDY]);
    end
    v = count_t(B_FIN, 50) + count_t(B_DONE, 50);
    checks++; if (v !== 0) begin failures++; $display("FAIL abort_mid_no_final got=%0d want=0", v); end
    run_block(1'b0, -1, 0, -1, 1'b0, 70, merr);
    v = count_t(B_KEN, 70);
    checks++;
    if (merr !== 0 || v !== NR || trace[2][11:6] !== 6'd0 || first_t(B_DONE, 0, 70) !== 67) begin
      failures++;
      $display("FAIL abort_restart got merr=%0d kcount=%0d want 0/64", merr, v);
    end
  endtask

  task automatic test_abort_last();
    int merr, v;
    apply_reset();
    run_block(1'b1, -1, 0, 65, 1'b0, 70, merr);
    checks++; if (merr !== 0) begin failures++; $display("FAIL abort_last_model got=%0d diffs want=0", merr); end
    checks++;
    if (trace[65][11:6] !== 6'd63 || !trace[65][B_REN] || !trace[66][B_RDY]) begin
      failures++;
      $display("FAIL abort_last_state got addr=%0d ren=%0d rdy=%0d want 63/1/1",
               trace[65][11:6], trace[65][B_REN], trace[66][B_RDY]);
    end
    v = count_t(B_FIN, 70) + count_t(B_DONE, 70);
    checks++; if (v !== 0) begin failures++; $display("FAIL abort_last_no_final got=%0d want=0", v); end
  endtask

  task automatic test_back_to_back();
    int merr, v, d1, i2;
    apply_reset();
    run_block(1'b0, -1, 0, -1, 1'b1, 136, merr);
    checks++; if (merr !== 0) begin failures++; $display("FAIL b2b_model got=%0d diffs want=0", merr); end
    v = count_t(B_IV, 136);
    checks++; if (v !== 0) begin failures++; $display("FAIL b2b_iv_count got=%0d want=0", v); end
    d1 = first_t(B_DONE, 0, 136);
    i2 = first_t(B_INIT, 2, 136);
    checks++; if (i2 - d1 !== 2 || d1 !== 67) begin failures++; $display("FAIL b2b_gap got done=%0d init=%0d want 67/69", d1, i2); end
    v = count_t(B_INIT, 136);
    checks++; if (v !== 2) begin failures++; $display("FAIL b2b_init_count got=%0d want=2", v); end
  endtask

  task automatic test_async_reset();
    int merr, v;
    apply_reset();
    run_block(1'b1, -1, 0, -1, 1'b0, 22, merr);
    checks++;
    if (merr !== 0 || trace[22][11:6] !== 6'd20) begin
      failures++;
      $display("FAIL areset_setup got merr=%0d addr=%0d want 0/20", merr, trace[22][11:6]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== 15'h4000) begin failures++; $display("FAIL areset_immediate got=%h want=%h", obs, 15'h4000); end
    m_pos = -1; m_first = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs !== 15'h4000) begin failures++; $display("FAIL areset_release got=%h want=%h", obs, 15'h4000); end
    run_block(1'b0, -1, 0, -1, 1'b0, 70, merr);
    v = count_t(B_KEN, 70);
    checks++;
    if (merr !== 0 || v !== NR || trace[2][11:6] !== 6'd0) begin
      failures++;
      $display("FAIL areset_restart got merr=%0d kcount=%0d want 0/64", merr, v);
    end
  endtask

  task automatic test_random();
    logic [14:0] e;
    int nerr = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
      e = model_out(m_pos, m_first, w_valid_i);
      checks++;
      if (obs !== e) begin
        failures++;
        if (nerr < 5) $display("FAIL random_cycle_%0d got=%h want=%h", i, obs, e);
        nerr++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_abort_mid();
    test_abort_last();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
